// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for addsub_seq.
// master = producer/consumer side, slave = the arithmetic block.
interface addsub_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_seq.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first.
// Define ADDSUB_SEQ_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_seq_if.slave  bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_op;
  logic             r_carry;
  logic             r_zero;

  logic [DIGIT:0]   w_dsum;
  logic [WIDTH-1:0] w_digit_ext;
  logic [WIDTH-1:0] w_sum_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_last      = (r_cnt == CNT_W'(N - 1));
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands shift right one digit per step; result digits enter at the top
  // so after N steps r_sum holds the full word in its natural position.
  assign w_dsum      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                     + (DIGIT+1)'(r_carry);
  assign w_digit_ext = WIDTH'(w_dsum[DIGIT-1:0]);
  assign w_sum_next  = (r_sum >> DIGIT) | (w_digit_ext << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b ^ {WIDTH{bus.op}};
      r_op    <= bus.op;
      r_carry <= bus.op;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= w_sum_next;
      r_carry <= w_dsum[DIGIT];
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_zero <= (w_sum_next == '0);
    end
  end

`ifdef ADDSUB_SEQ_OVF_EN
  logic r_ovf;
  logic w_ovf_digit;

  // Carry into the digit MSB recovered from its sum bit, XORed with carry out.
  assign w_ovf_digit = (r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1]) ^ w_dsum[DIGIT];

  always_ff @(posedge clk) begin
    if (rst)                   r_ovf <= 1'b0;
    else if (w_step && w_last) r_ovf <= w_ovf_digit;
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_carry ^ r_op;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed corner cases plus randomized
// operations against an arithmetic reference model, at 16/4, 8/1 and 8/8.
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  addsub_seq_if #(.WIDTH(16)) if16 ();
  addsub_seq_if #(.WIDTH(8))  if8a ();
  addsub_seq_if #(.WIDTH(8))  if8b ();

  addsub_seq #(.WIDTH(16), .DIGIT(4)) u16  (.clk(clk), .rst(rst), .bus(if16));
  addsub_seq #(.WIDTH(8),  .DIGIT(1)) u8d1 (.clk(clk), .rst(rst), .bus(if8a));
  addsub_seq #(.WIDTH(8),  .DIGIT(8)) u8d8 (.clk(clk), .rst(rst), .bus(if8b));

  function automatic void model(input int w, input int a, input int b, input bit op,
                                output int s, output bit c, output bit v, output bit z);
    int m, ai, bi, r;
    bit sa, sb, sr;
    m  = (1 << w) - 1;
    ai = a & m;
    bi = b & m;
    r  = op ? (ai - bi) : (ai + bi);
    s  = r & m;
    c  = op ? (ai < bi) : bit'((r >> w) & 1);
    sa = bit'((ai >> (w - 1)) & 1);
    sb = bit'((bi >> (w - 1)) & 1);
    sr = bit'((s >> (w - 1)) & 1);
    v  = op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`ifndef ADDSUB_SEQ_OVF_EN
    v  = 1'b0;
`endif
    z  = (s == 0);
  endfunction

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic op,
                         output logic [15:0] s, output logic c, output logic v,
                         output logic z, output int lat);
    int guard = 0;
    while (!if16.in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if16.a = a; if16.b = b; if16.op = op; if16.in_valid = 1'b1; if16.out_ready = 1'b0;
    @(posedge clk); #1;
    if16.in_valid = 1'($urandom_range(0, 1));
    if16.a  = 16'($urandom);
    if16.b  = 16'($urandom);
    if16.op = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      if16.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end while (!if16.out_valid && lat < 50);
    if16.out_ready = 1'b0;
    if16.in_valid  = 1'b0;
    s = if16.sum; c = if16.cout; v = if16.ovf; z = if16.zero;
  endtask

  task automatic release16();
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic op,
                        output logic [7:0] s0, output logic [7:0] s1,
                        output logic [2:0] f0, output logic [2:0] f1,
                        output int l0, output int l1);
    int cyc = 0;
    bit d0 = 1'b0, d1 = 1'b0;
    s0 = 'x; s1 = 'x; f0 = 'x; f1 = 'x; l0 = 0; l1 = 0;
    if8a.a = a; if8a.b = b; if8a.op = op; if8a.in_valid = 1'b1; if8a.out_ready = 1'b0;
    if8b.a = a; if8b.b = b; if8b.op = op; if8b.in_valid = 1'b1; if8b.out_ready = 1'b0;
    @(posedge clk); #1;
    if8a.in_valid = 1'b0;
    if8b.in_valid = 1'b0;
    while (!(d0 && d1) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!d0 && if8a.out_valid) begin
        d0 = 1'b1; l0 = cyc; s0 = if8a.sum; f0 = {if8a.cout, if8a.ovf, if8a.zero};
      end
      if (!d1 && if8b.out_valid) begin
        d1 = 1'b1; l1 = cyc; s1 = if8b.sum; f1 = {if8b.cout, if8b.ovf, if8b.zero};
      end
    end
    if8a.out_ready = 1'b1;
    if8b.out_ready = 1'b1;
    @(posedge clk); #1;
    if8a.out_ready = 1'b0;
    if8b.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if16.in_valid = 1'b1; if16.a = 16'h1234; if16.b = 16'h0001; if16.op = 1'b0;
    if16.out_ready = 1'b0;
    if8a.in_valid = 1'b1; if8a.a = 8'h11; if8a.b = 8'h22; if8a.op = 1'b0; if8a.out_ready = 1'b0;
    if8b.in_valid = 1'b1; if8b.a = 8'h11; if8b.b = 8'h22; if8b.op = 1'b0; if8b.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({if16.in_ready, if16.out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_handshake got=%b exp=10", {if16.in_ready, if16.out_valid});
    end
    n_chk++;
    if (if16.sum !== 16'h0000) begin
      n_fail++; $display("FAIL reset_sum got=%h exp=0000", if16.sum);
    end
    n_chk++;
    if ({if16.cout, if16.ovf, if16.zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {if16.cout, if16.ovf, if16.zero});
    end
    n_chk++;
    if ({if8a.in_ready, if8a.out_valid, if8b.in_ready, if8b.out_valid} !== 4'b1010) begin
      n_fail++; $display("FAIL reset_8bit got=%b exp=1010",
                         {if8a.in_ready, if8a.out_valid, if8b.in_ready, if8b.out_valid});
    end
    rst = 1'b0;
    if16.in_valid = 1'b0; if8a.in_valid = 1'b0; if8b.in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({if16.in_ready, if16.out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_edge_no_accept got=%b exp=10", {if16.in_ready, if16.out_valid});
    end
  endtask

  task automatic test_add();
    logic [15:0] s; logic c, v, z; int lat;
    do_op16(16'h1234, 16'h0001, 1'b0, s, c, v, z, lat);
    n_chk++;
    if (s !== 16'h1235) begin n_fail++; $display("FAIL add_sum got=%h exp=1235", s); end
    n_chk++;
    if ({c, v, z} !== 3'b000) begin n_fail++; $display("FAIL add_flags got=%b exp=000", {c, v, z}); end
    n_chk++;
    if (lat !== 4) begin n_fail++; $display("FAIL add_latency got=%0d exp=4", lat); end
    release16();
    n_chk++;
    if ({if16.in_ready, if16.out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL add_return_idle got=%b exp=10", {if16.in_ready, if16.out_valid});
    end
  endtask

  task automatic test_sub_borrow();
    logic [15:0] s; logic c, v, z; int lat;
    do_op16(16'h0003, 16'h0005, 1'b1, s, c, v, z, lat);
    n_chk++;
    if (s !== 16'hFFFE) begin n_fail++; $display("FAIL sub_sum got=%h exp=fffe", s); end
    n_chk++;
    if ({c, v, z} !== 3'b100) begin n_fail++; $display("FAIL sub_flags got=%b exp=100", {c, v, z}); end
    release16();
  endtask

  task automatic test_overflow();
    logic [15:0] s; logic c, v, z; int lat;
    logic exp_v;
`ifdef ADDSUB_SEQ_OVF_EN
    exp_v = 1'b1;
`else
    exp_v = 1'b0;
`endif
    do_op16(16'h7FFF, 16'h0001, 1'b0, s, c, v, z, lat);
    n_chk++;
    if (s !== 16'h8000) begin n_fail++; $display("FAIL ovf_sum got=%h exp=8000", s); end
    n_chk++;
    if ({c, v, z} !== {1'b0, exp_v, 1'b0}) begin
      n_fail++; $display("FAIL ovf_flags got=%b exp=%b", {c, v, z}, {1'b0, exp_v, 1'b0});
    end
    release16();
  endtask

  task automatic test_zero_backpressure();
    logic [15:0] s; logic c, v, z; int lat;
    do_op16(16'h5555, 16'h5555, 1'b1, s, c, v, z, lat);
    n_chk++;
    if ({s, c, z} !== {16'h0000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL zero_result got=%h c=%b z=%b exp=0000 c=0 z=1", s, c, z);
    end
    for (int i = 0; i < 3; i++) begin
      if16.in_valid = 1'($urandom_range(0, 1));
      if16.a = 16'($urandom);
      @(posedge clk); #1;
      n_chk++;
      if ({if16.out_valid, if16.in_ready, if16.sum, if16.cout, if16.zero} !== {2'b10, 16'h0000, 2'b01}) begin
        n_fail++; $display("FAIL zero_hold cycle=%0d got v=%b r=%b sum=%h c=%b z=%b", i,
                           if16.out_valid, if16.in_ready, if16.sum, if16.cout, if16.zero);
      end
    end
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    n_chk++;
    if ({if16.in_ready, if16.out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL zero_release got=%b exp=10", {if16.in_ready, if16.out_valid});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic c, v, z; int lat;
    bit seen = 1'b0;
    if16.a = 16'h1111; if16.b = 16'h2222; if16.op = 1'b0; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({if16.in_ready, if16.out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_idle got=%b exp=10", {if16.in_ready, if16.out_valid});
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if16.out_valid) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_result got=%b exp=0", seen); end
    do_op16(16'h00FF, 16'h0001, 1'b0, s, c, v, z, lat);
    n_chk++;
    if ({s, c, z} !== {16'h0100, 2'b00}) begin
      n_fail++; $display("FAIL midreset_next got=%h c=%b z=%b exp=0100 c=0 z=0", s, c, z);
    end
    n_chk++;
    if (lat !== 4) begin n_fail++; $display("FAIL midreset_latency got=%0d exp=4", lat); end
    release16();
  endtask

  task automatic test_random();
    logic [15:0] s, a, b; logic c, v, z, op; int lat, es;
    bit ec, ev, ez;
    for (int i = 0; i < 30; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      if (i % 7 == 0) b = a;
      op = 1'($urandom_range(0, 1));
      model(16, int'(a), int'(b), op, es, ec, ev, ez);
      do_op16(a, b, op, s, c, v, z, lat);
      n_chk++;
      if (s !== es[15:0]) begin
        n_fail++; $display("FAIL rand_sum a=%h b=%h op=%b got=%h exp=%h", a, b, op, s, es[15:0]);
      end
      n_chk++;
      if ({c, v, z} !== {ec, ev, ez}) begin
        n_fail++; $display("FAIL rand_flags a=%h b=%h op=%b got=%b exp=%b", a, b, op, {c, v, z}, {ec, ev, ez});
      end
      n_chk++;
      if (lat !== 4) begin n_fail++; $display("FAIL rand_latency got=%0d exp=4", lat); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      release16();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qs[$];
    logic [2:0]  qf[$];
    int last = -1, es;
    bit acc, ec, ev, ez;
    if16.out_ready = 1'b1;
    if16.a = 16'($urandom); if16.b = 16'($urandom); if16.op = 1'($urandom_range(0, 1));
    if16.in_valid = 1'b1;
    for (int cyc = 0; cyc < 48; cyc++) begin
      if (cyc == 40) if16.in_valid = 1'b0;
      if (if16.out_valid) begin
        n_chk++;
        if (qs.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected_result sum=%h exp=none", if16.sum);
        end else if ({if16.sum, if16.cout, if16.ovf, if16.zero} !== {qs[0], qf[0]}) begin
          n_fail++; $display("FAIL b2b_result got=%h/%b exp=%h/%b", if16.sum,
                             {if16.cout, if16.ovf, if16.zero}, qs[0], qf[0]);
        end
        if (qs.size() != 0) begin void'(qs.pop_front()); void'(qf.pop_front()); end
      end
      acc = if16.in_ready && if16.in_valid;
      if (acc) begin
        model(16, int'(if16.a), int'(if16.b), if16.op, es, ec, ev, ez);
        qs.push_back(es[15:0]);
        qf.push_back({ec, ev, ez});
        if (last >= 0) begin
          n_chk++;
          if (cyc - last !== 6) begin
            n_fail++; $display("FAIL b2b_spacing got=%0d exp=6", cyc - last);
          end
        end
        last = cyc;
      end
      @(posedge clk); #1;
      if (acc) begin
        if16.a = 16'($urandom); if16.b = 16'($urandom); if16.op = 1'($urandom_range(0, 1));
      end
    end
    if16.out_ready = 1'b0;
    n_chk++;
    if (qs.size() !== 0) begin n_fail++; $display("FAIL b2b_drain got=%0d pending exp=0", qs.size()); end
  endtask

  task automatic test_sweep();
    logic [7:0] s0, s1, a, b; logic [2:0] f0, f1; int l0, l1, es;
    logic op; bit ec, ev, ez;
    do_op8(8'hFF, 8'h01, 1'b0, s0, s1, f0, f1, l0, l1);
    n_chk++;
    if ({s0, f0[2], f0[0]} !== {8'h00, 2'b11}) begin
      n_fail++; $display("FAIL sweep_d1_result got=%h flags=%b exp=00 c=1 z=1", s0, f0);
    end
    n_chk++;
    if ({s1, f1[2], f1[0]} !== {8'h00, 2'b11}) begin
      n_fail++; $display("FAIL sweep_d8_result got=%h flags=%b exp=00 c=1 z=1", s1, f1);
    end
    n_chk++;
    if (l0 !== 8) begin n_fail++; $display("FAIL sweep_d1_latency got=%0d exp=8", l0); end
    n_chk++;
    if (l1 !== 1) begin n_fail++; $display("FAIL sweep_d8_latency got=%0d exp=1", l1); end
    for (int i = 0; i < 8; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 1'($urandom_range(0, 1));
      model(8, int'(a), int'(b), op, es, ec, ev, ez);
      do_op8(a, b, op, s0, s1, f0, f1, l0, l1);
      n_chk++;
      if ({s0, f0} !== {es[7:0], ec, ev, ez}) begin
        n_fail++; $display("FAIL sweep_d1_rand a=%h b=%h op=%b got=%h/%b exp=%h/%b",
                           a, b, op, s0, f0, es[7:0], {ec, ev, ez});
      end
      n_chk++;
      if ({s1, f1} !== {es[7:0], ec, ev, ez}) begin
        n_fail++; $display("FAIL sweep_d8_rand a=%h b=%h op=%b got=%h/%b exp=%h/%b",
                           a, b, op, s1, f1, es[7:0], {ec, ev, ez});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_borrow();
    test_overflow();
    test_zero_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, with legal range 1..WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and op are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port op, input, 1 bit: 0 = add, 1 = subtract (a - b).
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: carry-out for add; borrow for subtract (1 iff a < b unsigned).
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow (see Configuration).
REQ-014 The block SHALL have port zero, output, 1 bit: 1 iff sum == 0.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, CALC and DONE; in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-016 In IDLE, an edge with in_valid=1 SHALL capture a, b XOR {WIDTH{op}}, op, and a carry register initialised to op, clear the digit counter, and move to CALC.
REQ-017 CALC SHALL process DIGIT bits per edge, LSB digit first, propagating the carry register between digits, for exactly N = WIDTH/DIGIT edges, then move to DONE.
REQ-018 Latency SHALL be exactly N edges from the accept edge; out_valid is first high in the cycle following the N-th CALC edge (WIDTH=16, DIGIT=4: accept at edge k, out_valid high after edge k+4).
REQ-019 When DIGIT == WIDTH, N SHALL be 1; no zero-length CALC is permitted.
REQ-020 cout SHALL equal the final carry XOR op.
REQ-021 zero SHALL be computed from the final sum.
REQ-022 sum, cout, ovf and zero SHALL be valid and stable throughout DONE.
REQ-023 In DONE, out_ready=1 at an edge SHALL complete the transfer and return to IDLE; in_ready is low in that cycle, so the minimum spacing between accepts is N+2 cycles.
REQ-024 While out_ready=0 in DONE, the block SHALL hold all outputs indefinitely.
REQ-025 Changes to a, b, op and in_valid outside IDLE SHALL be ignored.
REQ-026 out_ready outside DONE SHALL be ignored.
REQ-027 Unsigned wrap-around SHALL be reported only through cout; sum always wraps modulo 2^WIDTH.

Reset
REQ-028 While rst=1 at an edge, the FSM SHALL enter IDLE with: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=0, and the counter and carry cleared.
REQ-029 Reset SHALL take priority over all handshakes.
REQ-030 A reset during CALC or DONE SHALL abandon the operation with no result produced.
REQ-031 An in_valid present on the reset edge SHALL NOT be accepted.

Configuration
REQ-032 With macro ADDSUB_SEQ_OVF_EN defined, ovf SHALL equal the carry into the MSB XOR the carry out of the MSB for the final digit.
REQ-033 With ADDSUB_SEQ_OVF_EN undefined, no overflow logic SHALL be generated, and ovf SHALL be tied to 0.
REQ-034 All other behaviour SHALL be identical with and without ADDSUB_SEQ_OVF_EN.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-035 Add: a=0x1234, b=0x0001, op=0 -> sum=0x1235, cout=0, zero=0, out_valid exactly 4 edges after accept.
REQ-036 Subtract with borrow: a=0x0003, b=0x0005, op=1 -> sum=0xFFFE, cout=1, ovf=0.
REQ-037 Overflow: a=0x7FFF, b=0x0001, op=0 -> sum=0x8000, cout=0, ovf=1 with ADDSUB_SEQ_OVF_EN and ovf=0 without.
REQ-038 Zero plus backpressure: a=b=0x5555, op=1, out_ready held 0 for 3 cycles -> sum=0, zero=1, cout=0 held stable; return to IDLE on the edge where out_ready=1.
REQ-039 Reset mid-operation: rst pulsed on the 2nd CALC edge -> no out_valid; in_ready=1 next cycle; a following 0x00FF+0x0001 yields 0x0100.
REQ-040 Parameter sweep: WIDTH=8 with DIGIT in {1,8} -> 0xFF+0x01 gives sum=0x00, cout=1, zero=1, with latency 8 and 1 respectively.
